param_seq_detect: RTL and testbench

Parametrised serial bit-pattern detector. It is the successor to the fixed-pattern Mealy/Moore sequence detectors in the lab set. Pattern width, pattern value and don't-care mask are configurable, and the pattern and mask are runtime-loadable. It supports overlapping and non-overlapping modes, a bit-valid enable, and a saturating match counter. It sits on a 1-bit serial input stream and flags each occurrence of the programmed pattern with a registered one-cycle pulse.

---
 rtl/param_seq_detect.sv | 91 +++++++++
 tb/tb_param_seq_detect.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/param_seq_detect.sv
// Serial bit-pattern detector with a runtime-loadable pattern and don't-care mask.
// Supports overlapping or non-overlapping matching and has a saturating match counter.
module param_seq_detect #(
  parameter int unsigned     PAT_W       = 4,
  parameter int unsigned     CNT_W       = 8,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(4'b1011)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [PAT_W-1:0] mask_in,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
  output logic [PAT_W-1:0] pat_cur
);

  localparam int unsigned      FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] pat;
  logic [PAT_W-1:0] mask;
  logic [FILL_W-1:0] fill;

  logic [PAT_W-1:0]  hist_n_c;
  logic [FILL_W-1:0] fill_n_c;
  logic              match_c;
  logic              hit_c;
  logic [CNT_W-1:0]  cnt_inc_c;

  // Next history/fill and match decision for a sampled bit
  always_comb begin
    hist_n_c  = {hist[PAT_W-2:0], x};
    fill_n_c  = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
    match_c   = (fill_n_c == FILL_FULL) && (((hist_n_c ^ pat) & mask) == '0);
    hit_c     = en && !pat_load && match_c;
    cnt_inc_c = match_cnt + CNT_W'(1);
  end

  // Pattern registers, shift history and fill level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat  <= DEFAULT_PAT;
      mask <= '1;
      hist <= '0;
      fill <= '0;
    end else if (pat_load) begin
      pat  <= pat_in;
      mask <= mask_in;
      hist <= '0;
      fill <= '0;
    end else if (en) begin
      hist <= hist_n_c;
      // Non-overlapping mode discards the matched bits from the fill level
      fill <= (match_c && !overlap) ? '0 : fill_n_c;
    end
  end

  // Match pulse and saturating counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y         <= 1'b0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else begin
      y <= hit_c;
      if (hit_c && cnt_clr) begin
        match_cnt <= CNT_W'(1);
        cnt_sat   <= 1'b0;
      end else if (hit_c) begin
        if (match_cnt != CNT_MAX) begin
          match_cnt <= cnt_inc_c;
          cnt_sat   <= (cnt_inc_c == CNT_MAX);
        end
      end else if (cnt_clr) begin
        match_cnt <= '0;
        cnt_sat   <= 1'b0;
      end
    end
  end

  assign pat_cur = pat;

endmodule

// File: tb/tb_param_seq_detect.sv
// Directed self-checking bench for param_seq_detect (PAT_W=4, CNT_W=3).
module tb_param_seq_detect;

  localparam int unsigned PAT_W = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             x;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic [PAT_W-1:0] mask_in;
  logic             overlap;
  logic             cnt_clr;
  logic             y;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;
  logic [PAT_W-1:0] pat_cur;

  int checks = 0;
  int errors = 0;

  param_seq_detect #(
    .PAT_W      (PAT_W),
    .CNT_W      (CNT_W),
    .DEFAULT_PAT(4'b1011)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .x        (x),
    .pat_load (pat_load),
    .pat_in   (pat_in),
    .mask_in  (mask_in),
    .overlap  (overlap),
    .cnt_clr  (cnt_clr),
    .y        (y),
    .match_cnt(match_cnt),
    .cnt_sat  (cnt_sat),
    .pat_cur  (pat_cur)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // One clock with the given en/x; returns #1 after the edge
  task automatic step(input logic e, input logic b);
    en       = e;
    x        = b;
    pat_load = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [PAT_W-1:0] p, input logic [PAT_W-1:0] m,
                      input logic e, input logic b);
    en       = e;
    x        = b;
    pat_load = 1'b1;
    pat_in   = p;
    mask_in  = m;
    @(posedge clk);
    #1;
    pat_load = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Feed n bits (MSB first) with en=1 and check y after each edge
  task automatic run_seq(input string tag, input logic [15:0] bits,
                         input int n, input logic [15:0] yexp);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, bits[i]);
      chk($sformatf("%s_y%0d", tag, n - i), 32'(y), 32'(yexp[i]));
    end
  endtask

  initial begin
    reset    = 1'b1;
    en       = 1'b0;
    x        = 1'b0;
    pat_load = 1'b0;
    pat_in   = '0;
    mask_in  = '0;
    overlap  = 1'b1;
    cnt_clr  = 1'b0;
    #2;
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    chk("rst_sat", 32'(cnt_sat), 32'd0);
    chk("rst_pat", 32'(pat_cur), 32'hB);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Test 1: default pattern 1011, overlapping
    run_seq("t1", 16'b01011110010000, 14, 16'b00001000000000);
    chk("t1_cnt", 32'(match_cnt), 32'd1);

    // Test 2a: pattern 1010 overlapping
    do_reset();
    overlap = 1'b1;
    load(4'b1010, 4'b1111, 1'b0, 1'b0);
    chk("t2_pat", 32'(pat_cur), 32'hA);
    run_seq("t2a", 16'b101010, 6, 16'b000101);
    chk("t2a_cnt", 32'(match_cnt), 32'd2);

    // Test 2b: same, non-overlapping
    do_reset();
    overlap = 1'b0;
    load(4'b1010, 4'b1111, 1'b0, 1'b0);
    run_seq("t2b", 16'b101010, 6, 16'b000100);
    chk("t2b_cnt", 32'(match_cnt), 32'd1);

    // Test 3: masked pattern, then again with an en=0 gap
    do_reset();
    overlap = 1'b0;
    load(4'b1000, 4'b1001, 1'b0, 1'b0);
    run_seq("t3a", 16'b11101010, 8, 16'b00010001);
    chk("t3a_cnt", 32'(match_cnt), 32'd2);
    do_reset();
    load(4'b1000, 4'b1001, 1'b0, 1'b0);
    run_seq("t3b1", 16'b11, 2, 16'b00);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      chk($sformatf("t3b_gap%0d", i), 32'(y), 32'd0);
    end
    run_seq("t3b2", 16'b101010, 6, 16'b010001);
    chk("t3b_cnt", 32'(match_cnt), 32'd2);

    // Mask all zero: every bit matches once the history is full
    do_reset();
    overlap = 1'b1;
    load(4'b0000, 4'b0000, 1'b0, 1'b0);
    run_seq("m0", 16'b11111, 5, 16'b00011);

    // Test 4: saturation at 7 with CNT_W=3
    do_reset();
    overlap = 1'b1;
    load(4'b1111, 4'b1111, 1'b0, 1'b0);
    run_seq("t4a", 16'h1FF, 9, 16'b000111111);
    chk("t4_cnt6", 32'(match_cnt), 32'd6);
    chk("t4_sat6", 32'(cnt_sat), 32'd0);
    run_seq("t4b", 16'b1, 1, 16'b1);
    chk("t4_cnt7", 32'(match_cnt), 32'd7);
    chk("t4_sat7", 32'(cnt_sat), 32'd1);
    run_seq("t4c", 16'b1, 1, 16'b1);
    chk("t4_cnt8", 32'(match_cnt), 32'd7);
    chk("t4_sat8", 32'(cnt_sat), 32'd1);
    cnt_clr = 1'b1;
    step(1'b1, 1'b1);
    cnt_clr = 1'b0;
    chk("t4_clr_y", 32'(y), 32'd1);
    chk("t4_clr_cnt", 32'(match_cnt), 32'd1);
    chk("t4_clr_sat", 32'(cnt_sat), 32'd0);
    cnt_clr = 1'b1;
    step(1'b0, 1'b0);
    cnt_clr = 1'b0;
    chk("t4_clr0_cnt", 32'(match_cnt), 32'd0);

    // Test 5: asynchronous reset while y is high
    do_reset();
    overlap = 1'b1;
    load(4'b1010, 4'b1111, 1'b0, 1'b0);
    run_seq("t5", 16'b101010, 6, 16'b000101);
    chk("t5_cnt_pre", 32'(match_cnt), 32'd2);
    reset = 1'b1;
    #2;
    chk("t5_async_y", 32'(y), 32'd0);
    chk("t5_async_cnt", 32'(match_cnt), 32'd0);
    chk("t5_async_pat", 32'(pat_cur), 32'hB);
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_seq("t5b", 16'b01011, 5, 16'b00001);

    // Test 6: pat_load wins over a valid bit on the same edge
    do_reset();
    overlap = 1'b1;
    run_seq("t6a", 16'b101, 3, 16'b000);
    load(4'b1011, 4'b1111, 1'b1, 1'b1);
    chk("t6_load_y", 32'(y), 32'd0);
    chk("t6_pat", 32'(pat_cur), 32'hB);
    run_seq("t6b", 16'b1011, 4, 16'b0001);
    chk("t6_cnt", 32'(match_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
